// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution scheduler slice.
//
// Contents:
//   conv_state_t  - scheduler states IDLE, RUN, DRAIN, WRITE, DONE
//   acc_width()   - accumulator width that cannot overflow for a given
//                   sample width and kernel size
//   sat_to_width()- clamp a wide signed value into a signed width
//
// Optional build macro used by this slice: CONV_SCHED_RELU_EN
// (handled in conv_mac; nothing here depends on it).

package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } conv_state_t;

    // Sum of size_ker^2 products of two width_bit signed samples, plus one
    // guard bit so the most negative product sum still fits.
    function automatic int acc_width(input int width_bit, input int size_ker);
        return 2 * width_bit + $clog2(size_ker * size_ker) + 1;
    endfunction

    // Clamp to [-2^(width-1), 2^(width-1)-1]; the caller keeps the low
    // 'width' bits of the result.
    function automatic logic signed [63:0] sat_to_width(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: shared signed multiply-accumulate with a saturating output stage.
//
// Ports:
//   clock, nreset      - rising-edge clock, async active-low reset
//   clear              - synchronous accumulator clear (wins over acc_en)
//   acc_en             - add img_data*ker_data into the accumulator this cycle
//   load               - capture the saturated result into out_data; if acc_en
//                        is also high, the product being added is included
//   img_data, ker_data - signed samples (WIDTH_BIT)
//   out_data           - registered signed saturated result (WIDTH_BIT)
//
// Build macro CONV_SCHED_RELU_EN: when defined, negative results are written
// as 0; otherwise plain signed saturation.

module conv_mac
    import conv_pkg::*;
#(
    parameter int WIDTH_BIT = 8,
    parameter int SIZEKer   = 3
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        clear,
    input  logic                        acc_en,
    input  logic                        load,
    input  logic signed [WIDTH_BIT-1:0] img_data,
    input  logic signed [WIDTH_BIT-1:0] ker_data,
    output logic signed [WIDTH_BIT-1:0] out_data
);

    localparam int ACC_W  = acc_width(WIDTH_BIT, SIZEKer);
    localparam int PROD_W = 2 * WIDTH_BIT;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [ACC_W-1:0]     acc_sel;
    logic signed [63:0]          acc_wide;
    logic signed [WIDTH_BIT-1:0] result;

    // The final tap arrives in the same cycle the result is captured, so the
    // output stage looks at the accumulator value including that product.
    always_comb begin
        prod     = PROD_W'(img_data) * PROD_W'(ker_data);
        acc_next = acc + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        acc_sel  = acc_en ? acc_next : acc;
        acc_wide = {{(64 - ACC_W){acc_sel[ACC_W-1]}}, acc_sel};
`ifdef CONV_SCHED_RELU_EN
        result   = acc_sel[ACC_W-1] ? '0 : WIDTH_BIT'(sat_to_width(acc_wide, WIDTH_BIT));
`else
        result   = WIDTH_BIT'(sat_to_width(acc_wide, WIDTH_BIT));
`endif
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            acc      <= '0;
            out_data <= '0;
        end else begin
            if (clear) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc_next;
            end
            if (load) begin
                out_data <= result;
            end
        end
    end

endmodule

// File: rtl/conv_scheduler.sv
// conv_scheduler: walks one shared MAC over a SIZE x SIZE image with a
// SIZEKer x SIZEKer kernel, producing the valid-convolution outputs in
// raster order.
//
// Ports:
//   clock, nreset            - rising-edge clock, async active-low reset
//   start                    - level request, accepted in IDLE or DONE
//   busy, done               - run in progress / finished until next start
//   img_row, img_col         - image read address
//   ker_row, ker_col         - kernel read address
//   rd_en                    - read strobe for both memories
//   img_data, ker_data       - read data, valid one cycle after rd_en
//   out_valid                - one-cycle pulse per output pixel
//   out_row, out_col         - output coordinates (held between pulses)
//   out_data                 - saturated result (held between pulses)
//
// Build macro CONV_SCHED_RELU_EN: clamps negative results to 0 (timing
// unchanged).
//
// Per output: SIZEKer^2 RUN cycles (one tap each), one DRAIN cycle for the
// last tap's read latency, one WRITE cycle presenting the result.

module conv_scheduler
    import conv_pkg::*;
#(
    parameter int SIZE      = 64,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8,
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int KW = (SIZEKer > 1) ? $clog2(SIZEKer) : 1
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [AW-1:0]               img_row,
    output logic [AW-1:0]               img_col,
    output logic [KW-1:0]               ker_row,
    output logic [KW-1:0]               ker_col,
    output logic                        rd_en,
    input  logic signed [WIDTH_BIT-1:0] img_data,
    input  logic signed [WIDTH_BIT-1:0] ker_data,
    output logic                        out_valid,
    output logic [AW-1:0]               out_row,
    output logic [AW-1:0]               out_col,
    output logic signed [WIDTH_BIT-1:0] out_data
);

    localparam logic [AW-1:0] LAST_OUT = AW'(SIZE - SIZEKer);
    localparam logic [KW-1:0] LAST_TAP = KW'(SIZEKer - 1);

    conv_state_t   state;
    conv_state_t   next_state;

    logic [AW-1:0] orow;
    logic [AW-1:0] ocol;
    logic [KW-1:0] ki;
    logic [KW-1:0] kj;
    logic          rd_en_q;
    logic          start_accept;
    logic          last_tap;
    logic          last_out;

    assign start_accept = start && ((state == IDLE) || (state == DONE));
    assign last_tap     = (ki == LAST_TAP) && (kj == LAST_TAP);
    assign last_out     = (orow == LAST_OUT) && (ocol == LAST_OUT);

    assign img_row = orow + AW'(ki);
    assign img_col = ocol + AW'(kj);
    assign ker_row = ki;
    assign ker_col = kj;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (last_tap) next_state = DRAIN;
            end
            DRAIN: begin
                busy       = 1'b1;
                next_state = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                next_state = last_out ? DONE : RUN;
            end
            DONE: begin
                done = 1'b1;
                if (start) next_state = RUN;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Tap counters wrap back to 0 on the last tap so the next output's RUN
    // phase starts clean; output coordinates are latched in DRAIN so they
    // are already stable when WRITE raises out_valid.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            orow    <= '0;
            ocol    <= '0;
            ki      <= '0;
            kj      <= '0;
            rd_en_q <= 1'b0;
            out_row <= '0;
            out_col <= '0;
        end else begin
            rd_en_q <= rd_en;
            if (start_accept) begin
                orow <= '0;
                ocol <= '0;
                ki   <= '0;
                kj   <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (kj == LAST_TAP) begin
                            kj <= '0;
                            ki <= last_tap ? '0 : ki + KW'(1);
                        end else begin
                            kj <= kj + KW'(1);
                        end
                    end
                    DRAIN: begin
                        out_row <= orow;
                        out_col <= ocol;
                    end
                    WRITE: begin
                        if (!last_out) begin
                            if (ocol == LAST_OUT) begin
                                ocol <= '0;
                                orow <= orow + AW'(1);
                            end else begin
                                ocol <= ocol + AW'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    conv_mac #(
        .WIDTH_BIT (WIDTH_BIT),
        .SIZEKer   (SIZEKer)
    ) u_mac (
        .clock    (clock),
        .nreset   (nreset),
        .clear    (start_accept || (state == WRITE)),
        .acc_en   (rd_en_q),
        .load     (state == DRAIN),
        .img_data (img_data),
        .ker_data (ker_data),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler: self-checking bench for conv_scheduler.
// Main instance SIZE=4, SIZEKer=3; a second instance SIZE=SIZEKer=3 covers
// the single-output case. Expected results come from a plain arithmetic
// convolution model over the bench's image/kernel arrays.
// Honours CONV_SCHED_RELU_EN in its expectations.

module tb_conv_scheduler;

    localparam int SIZE  = 4;
    localparam int SKER  = 3;
    localparam int WB    = 8;
    localparam int NOUT  = SIZE - SKER + 1;
    localparam int M     = NOUT * NOUT;
    localparam int K2    = SKER * SKER;
    localparam int P     = K2 + 2;

`ifdef CONV_SCHED_RELU_EN
    localparam int NEG128 = 0;
    localparam int NEG9   = 0;
`else
    localparam int NEG128 = -128;
    localparam int NEG9   = -9;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 nreset;
    logic                 start;
    logic                 busy, done, rd_en, out_valid;
    logic [1:0]           img_row, img_col, ker_row, ker_col, out_row, out_col;
    logic signed [WB-1:0] img_data, ker_data, out_data;

    logic                 sq_start;
    logic                 sq_busy, sq_done, sq_rd_en, sq_out_valid;
    logic [1:0]           sq_img_row, sq_img_col, sq_ker_row, sq_ker_col, sq_out_row, sq_out_col;
    logic signed [WB-1:0] sq_img_data, sq_ker_data, sq_out_data;

    conv_scheduler #(.SIZE(SIZE), .SIZEKer(SKER), .WIDTH_BIT(WB)) u_dut (
        .clock(clock), .nreset(nreset), .start(start), .busy(busy), .done(done),
        .img_row(img_row), .img_col(img_col), .ker_row(ker_row), .ker_col(ker_col),
        .rd_en(rd_en), .img_data(img_data), .ker_data(ker_data),
        .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_data(out_data)
    );

    conv_scheduler #(.SIZE(3), .SIZEKer(3), .WIDTH_BIT(WB)) u_dut_sq (
        .clock(clock), .nreset(nreset), .start(sq_start), .busy(sq_busy), .done(sq_done),
        .img_row(sq_img_row), .img_col(sq_img_col), .ker_row(sq_ker_row), .ker_col(sq_ker_col),
        .rd_en(sq_rd_en), .img_data(sq_img_data), .ker_data(sq_ker_data),
        .out_valid(sq_out_valid), .out_row(sq_out_row), .out_col(sq_out_col), .out_data(sq_out_data)
    );

    logic signed [WB-1:0] img_mem [0:SIZE-1][0:SIZE-1];
    logic signed [WB-1:0] ker_mem [0:SKER-1][0:SKER-1];

    // Synchronous-read memories; idle cycles return junk so stray
    // accumulation shows up in the results.
    always @(posedge clock) begin
        if (rd_en) begin
            img_data <= img_mem[img_row][img_col];
            ker_data <= ker_mem[ker_row][ker_col];
        end else begin
            img_data <= WB'($urandom);
            ker_data <= WB'($urandom);
        end
        if (sq_rd_en) begin
            sq_img_data <= img_mem[sq_img_row][sq_img_col];
            sq_ker_data <= ker_mem[sq_ker_row][sq_ker_col];
        end else begin
            sq_img_data <= WB'($urandom);
            sq_ker_data <= WB'($urandom);
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: direct valid-convolution at output (r,c), then clamp.
    function automatic int model_out(input int r, input int c);
        int s;
        s = 0;
        for (int i = 0; i < SKER; i++)
            for (int j = 0; j < SKER; j++)
                s += int'(img_mem[r+i][c+j]) * int'(ker_mem[i][j]);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
`ifdef CONV_SCHED_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    int got_row[$], got_col[$], got_data[$], got_cyc[$];
    int sq_pulses = 0;
    int sq_pulse_cyc = 0;
    bit window = 1'b0;
    int start_cyc = 0;

    // Sampled 1 time unit after the falling edge; while a run window is open
    // the expected control/address pattern follows from the cycle offset.
    always @(negedge clock) begin : monitor
        int off, o, t, orow, ocol, ki, kj;
        #1;
        if (out_valid) begin
            got_row.push_back(int'(out_row));
            got_col.push_back(int'(out_col));
            got_data.push_back(int'(out_data));
            got_cyc.push_back(cyc);
        end
        if (sq_out_valid) begin
            sq_pulses++;
            sq_pulse_cyc = cyc;
        end
        if (window) begin
            off = cyc - start_cyc;
            o = off / P;
            t = off % P;
            if (o < M) begin
                check("ctl", {busy, done, rd_en, out_valid},
                      {1'b1, 1'b0, (t < K2), (t == K2 + 1)});
                if (t < K2) begin
                    orow = o / NOUT; ocol = o % NOUT;
                    ki = t / SKER;   kj = t % SKER;
                    check("addr", {img_row, img_col, ker_row, ker_col},
                          {2'(orow + ki), 2'(ocol + kj), 2'(ki), 2'(kj)});
                end
            end
        end
    end

    typedef struct {
        string name;
        int    img_mode;   // 0: constant, 1: ramp r*SIZE+c
        int    img_val;
        int    ker_mode;   // 0: constant, 1: centre tap only
        int    ker_val;
        int    exp_data [4];
    } vec_t;

    vec_t tab [5];

    function automatic void set_vec(input int idx, input string nm, input int im, input int iv,
                                    input int km, input int kv,
                                    input int e0, input int e1, input int e2, input int e3);
        tab[idx].name = nm;
        tab[idx].img_mode = im; tab[idx].img_val = iv;
        tab[idx].ker_mode = km; tab[idx].ker_val = kv;
        tab[idx].exp_data[0] = e0; tab[idx].exp_data[1] = e1;
        tab[idx].exp_data[2] = e2; tab[idx].exp_data[3] = e3;
    endfunction

    task automatic apply_stimulus(input int v);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++)
                img_mem[r][c] = (tab[v].img_mode == 1) ? WB'(r * SIZE + c) : WB'(tab[v].img_val);
        for (int i = 0; i < SKER; i++)
            for (int j = 0; j < SKER; j++)
                if (tab[v].ker_mode == 1)
                    ker_mem[i][j] = (i == SKER / 2 && j == SKER / 2) ? WB'(1) : WB'(0);
                else
                    ker_mem[i][j] = WB'(tab[v].ker_val);
    endtask

    task automatic check_output(input int v);
        for (int i = 0; i < M; i++)
            if (i < got_data.size())
                check({tab[v].name, "_tab_data"}, got_data[i], tab[v].exp_data[i]);
    endtask

    // One full run: start pulse, optional extra start at offset restart_at,
    // bounded wait for done, then compare pulses against the model.
    task automatic run_conv(input string tag, input int restart_at);
        int n;
        got_row.delete(); got_col.delete(); got_data.delete(); got_cyc.delete();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0; start_cyc = cyc; window = 1'b1;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
            start = (restart_at > 0) && (cyc == start_cyc + restart_at);
        end
        start = 1'b0;
        window = 1'b0;
        check({tag, "_done_cycle"}, cyc - start_cyc, M * P);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_pulses"}, got_data.size(), M);
        for (int i = 0; i < M; i++) begin
            if (i < got_data.size()) begin
                check({tag, "_row"}, got_row[i], i / NOUT);
                check({tag, "_col"}, got_col[i], i % NOUT);
                check({tag, "_data"}, got_data[i], model_out(i / NOUT, i % NOUT));
                check({tag, "_pulse_cycle"}, got_cyc[i] - start_cyc, i * P + K2 + 1);
            end
        end
    endtask

    task automatic run_reset_mid();
        int n;
        got_row.delete(); got_col.delete(); got_data.delete(); got_cyc.delete();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0; start_cyc = cyc;
        n = 0;
        while (cyc < start_cyc + 15 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("rst_pre_pulses", got_data.size(), 1);
        #2 nreset = 1'b0;
        #1;
        check("rst_async_outputs",
              {busy, done, rd_en, out_valid, img_row, img_col, ker_row, ker_col,
               out_row, out_col, out_data}, 0);
        got_data.delete(); got_row.delete(); got_col.delete(); got_cyc.delete();
        repeat (40) @(negedge clock);
        check("rst_no_pulses", got_data.size(), 0);
        check("rst_idle", {busy, done}, 0);
        nreset = 1'b1;
    endtask

    task automatic run_square();
        int n, s0;
        sq_pulses = 0;
        @(negedge clock); sq_start = 1'b1;
        @(negedge clock); sq_start = 1'b0; s0 = cyc;
        n = 0;
        while (!sq_done && n < 100) begin
            @(negedge clock);
            n++;
        end
        #2;
        check("sq_done_cycle", cyc - s0, K2 + 2);
        check("sq_pulses", sq_pulses, 1);
        check("sq_pulse_cycle", sq_pulse_cyc - s0, K2 + 1);
        check("sq_coord", {sq_out_row, sq_out_col}, 0);
        check("sq_data", sq_out_data, model_out(0, 0));
    endtask

    initial begin
        nreset = 1'b0;
        start = 1'b0;
        sq_start = 1'b0;

        set_vec(0, "ones",   0,    1, 0,   1, 9, 9, 9, 9);
        set_vec(1, "sat127", 0,  127, 0, 127, 127, 127, 127, 127);
        set_vec(2, "neg128", 0, -128, 0,   1, NEG128, NEG128, NEG128, NEG128);
        set_vec(3, "ramp",   1,    0, 1,   0, 5, 6, 9, 10);
        set_vec(4, "neg1",   0,   -1, 0,   1, NEG9, NEG9, NEG9, NEG9);

        repeat (2) @(negedge clock);
        check("reset_state",
              {busy, done, rd_en, out_valid, img_row, img_col, ker_row, ker_col,
               out_row, out_col, out_data}, 0);
        nreset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            apply_stimulus(v);
            run_conv(tab[v].name, 0);
            check_output(v);
        end

        apply_stimulus(0);
        run_conv("restart_ignored", 10);
        check_output(0);
        run_conv("second_run", 0);
        check_output(0);

        run_reset_mid();
        apply_stimulus(0);
        run_conv("after_reset", 0);
        check_output(0);

        apply_stimulus(3);
        run_square();

        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++)
                    img_mem[r][c] = (k % 2 == 1) ? WB'($urandom_range(0, 20) - 10) : WB'($urandom);
            for (int i = 0; i < SKER; i++)
                for (int j = 0; j < SKER; j++)
                    ker_mem[i][j] = (k % 2 == 1) ? WB'($urandom_range(0, 2) - 1) : WB'($urandom);
            run_conv("random", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
